edf_queue_scheduler: RTL
========================

Name: edf_queue_scheduler

Overview:
- Earliest-Deadline-First arbiter that drains NUM_QUEUES per-requester Queue instances onto one shared memory-side output port.
- Keeps a per-queue remaining-time counter and a programmable period.
- Pops the head of the non-empty queue with the smallest remaining time, presents it downstream with a valid/ready handshake, then reloads that queue's counter with its period.

Parameters:
- NUM_QUEUES, 4, number of requester queues arbitrated (≥2).
- DATA_WIDTH, 8, width of each queue entry.
- DEADLINE_WIDTH, 16, width of period and remaining-time counters.
- DEFAULT_PERIOD, 100, period and counter value loaded at reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- queueValue  in  NUM_QUEUES*DATA_WIDTH  head entry of each queue; slice i = queue i; valid when queueEmpty[i]=0.
- queueEmpty  in  NUM_QUEUES  empty flag of each queue.
- queueConsume  out  NUM_QUEUES  one-cycle pop strobe per queue.
- periodIn  in  DEADLINE_WIDTH  new period value.
- periodWrite  in  NUM_QUEUES  one-hot; writes periodIn into period[i].
- dataOut  out  DATA_WIDTH  granted entry.
- dataOutValid  out  1  dataOut valid.
- dataOutReady  in  1  downstream accepts.
- grantId  out  $clog2(NUM_QUEUES)  index of the queue that sourced dataOut.
- idle  out  1  FSM in IDLE.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE; queueConsume=0; dataOutValid=0; dataOut=0; grantId=0; idle=1.
  - period[i]=DEFAULT_PERIOD; remaining[i]=DEFAULT_PERIOD.
  - Reset mid-transaction drops any held entry; the popped entry is lost by design.
- Counters:
  - Each cycle remaining[i] decrements by 1, saturating at 0.
  - In the ISSUE cycle, remaining[winner] reloads to period[winner]. Reload has priority over decrement.
- Period writes:
  - period[i]<=periodIn on periodWrite[i], effective next cycle.
  - A write does not alter remaining[i]; it takes effect at the next reload.
  - Multiple bits set in periodWrite write all flagged entries.
  - Period 0 is legal and means always most urgent after service.
- Selection:
  - Candidates are queues with queueEmpty[i]=0.
  - Winner = argmin remaining[i] among candidates, unsigned compare.
  - Ties go to the lowest index.
- FSM:
  - IDLE:
    - idle=1.
    - If any candidate exists, register winner into grantId and go to ISSUE; else stay.
  - ISSUE:
    - queueConsume[grantId]=1 for exactly this cycle.
    - dataOut<=queueValue slice grantId.
    - Reload the counter.
    - Go to HOLD.
  - HOLD:
    - dataOutValid=1; dataOut and grantId stable.
    - On dataOutReady=1, go to IDLE with dataOutValid=0 next cycle.
    - Otherwise hold indefinitely; counters keep decrementing.
- Latency and throughput:
  - A candidate present in IDLE at cycle t gives consume at t+1 and dataOutValid at t+2.
  - Minimum 3 cycles per grant when dataOutReady is tied high.
- Invariants:
  - At most one queueConsume bit is set in any cycle, and only in ISSUE.
  - This block is the only consumer of the queues, so the winner cannot go empty between IDLE and ISSUE.
  - The scheduler never pops a queue whose queueEmpty=1 at the ISSUE edge.
- Arrivals: entries arriving during ISSUE or HOLD are evaluated at the next IDLE.

Decomposition:
- Package memoredf_sched_pkg holds:
  - state enum {IDLE, ISSUE, HOLD};
  - default widths and DEFAULT_PERIOD constant;
  - helper function for the index width.
- Sub-module edf_min_select: combinational argmin tree over remaining[] masked by ~queueEmpty. Outputs winner index and anyValid, with lowest-index tie-break.
- Counters, period registers and the FSM stay in edf_queue_scheduler.

Test Plan:
- Reset, then all queues empty for 20 cycles -> idle=1, queueConsume=0, dataOutValid=0, remaining[i] counts 100→80.
- Reset; queue 2 holds 0x5A; dataOutReady=1 -> consume[2] at t+1, dataOut=0x5A, grantId=2, dataOutValid at t+2 for 1 cycle; remaining[2] reloads to 100.
- Periods {40,10,100,100} written at cycle 0, then all queues filled with one entry each at cycle 100 (remaining all 0 on entry) -> grant order by tie then reload: 0,1,2,3. Subsequent refills grant queue 1 before queue 0 (10 < 40).
- Queues 0 and 3 non-empty with remaining 5 and 5 -> queue 0 granted (lowest-index tie-break).
- dataOutReady held low 10 cycles in HOLD -> dataOut/grantId stable, no further queueConsume; release -> IDLE next cycle.
- Assert reset during HOLD -> dataOutValid=0 immediately (async), counters=DEFAULT_PERIOD; after release, normal grants resume.

Source files
------------

// File: rtl/memoredf_sched_pkg.sv
// Shared types and defaults for the EDF queue scheduler.
package memoredf_sched_pkg;

  localparam int unsigned DEF_NUM_QUEUES     = 4;
  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_DEADLINE_WIDTH = 16;
  localparam int unsigned DEF_PERIOD         = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Index width for a queue count of at least two.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edf_queue_scheduler_min_select.sv
// Combinational argmin over remaining times of the non-empty queues.
module edf_min_select
  import memoredf_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES     = DEF_NUM_QUEUES,
  parameter int unsigned DEADLINE_WIDTH = DEF_DEADLINE_WIDTH,
  parameter int unsigned IDX_W          = idx_width(DEF_NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0][DEADLINE_WIDTH-1:0] remaining,
  input  logic [NUM_QUEUES-1:0]                     valid,
  output logic [IDX_W-1:0]                          winner,
  output logic                                      anyValid
);

  logic [DEADLINE_WIDTH-1:0] best;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    winner   = '0;
    anyValid = 1'b0;
    best     = '0;
    for (int i = 0; i < int'(NUM_QUEUES); i++) begin
      if (valid[i] && (!anyValid || (remaining[i] < best))) begin
        winner   = IDX_W'(i);
        best     = remaining[i];
        anyValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edf_queue_scheduler.sv
// Earliest-deadline-first arbiter draining per-requester queues onto one
// valid/ready output; per-queue deadline counters reload on service.
module edf_queue_scheduler
  import memoredf_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES     = DEF_NUM_QUEUES,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned DEADLINE_WIDTH = DEF_DEADLINE_WIDTH,
  parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
  localparam int unsigned IDX_W         = idx_width(NUM_QUEUES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] queueValue,
  input  logic [NUM_QUEUES-1:0]            queueEmpty,
  output logic [NUM_QUEUES-1:0]            queueConsume,
  input  logic [DEADLINE_WIDTH-1:0]        periodIn,
  input  logic [NUM_QUEUES-1:0]            periodWrite,
  output logic [DATA_WIDTH-1:0]            dataOut,
  output logic                             dataOutValid,
  input  logic                             dataOutReady,
  output logic [IDX_W-1:0]                 grantId,
  output logic                             idle
);

  state_t state_q, state_d;

  logic [NUM_QUEUES-1:0][DEADLINE_WIDTH-1:0] period_q;
  logic [NUM_QUEUES-1:0][DEADLINE_WIDTH-1:0] remaining_q;
  logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0]     entries;

  logic [IDX_W-1:0]      winner;
  logic                  any_valid;
  logic [NUM_QUEUES-1:0] consume_d;
  logic [IDX_W-1:0]      grant_d;
  logic [DATA_WIDTH-1:0] dout_d;

  assign entries = queueValue;

  edf_min_select #(
    .NUM_QUEUES     (NUM_QUEUES),
    .DEADLINE_WIDTH (DEADLINE_WIDTH),
    .IDX_W          (IDX_W)
  ) u_min_select (
    .remaining (remaining_q),
    .valid     (~queueEmpty),
    .winner    (winner),
    .anyValid  (any_valid)
  );

  // Period registers and saturating deadline counters; reload beats decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        period_q[i]    <= DEADLINE_WIDTH'(DEFAULT_PERIOD);
        remaining_q[i] <= DEADLINE_WIDTH'(DEFAULT_PERIOD);
      end
    end else begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        if (periodWrite[i]) begin
          period_q[i] <= periodIn;
        end
        if ((state_q == ISSUE) && (grantId == IDX_W'(i))) begin
          remaining_q[i] <= period_q[i];
        end else if (remaining_q[i] != '0) begin
          remaining_q[i] <= remaining_q[i] - DEADLINE_WIDTH'(1);
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    consume_d = '0;
    grant_d   = grantId;
    dout_d    = dataOut;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d   = ISSUE;
          grant_d   = winner;
          consume_d = NUM_QUEUES'(1) << winner;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        dout_d  = entries[grantId];
      end
      HOLD: begin
        if (dataOutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; the pop strobe lands in the ISSUE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      queueConsume <= '0;
      grantId      <= '0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state_q      <= state_d;
      queueConsume <= consume_d;
      grantId      <= grant_d;
      dataOut      <= dout_d;
      dataOutValid <= (state_d == HOLD);
      idle         <= (state_d == IDLE);
    end
  end

endmodule
